// File: rtl/uart_rx_param_if.sv
// ---------------------------------------------------------------------------
// uart_rx_param_if
// Output-side bundle of the parametrised UART receiver.
//   data        received word, LSB = first data bit on the line
//   data_valid  word held on data until accepted
//   data_ready  consumer accept; transfer when data_valid && data_ready
//   parity_err  parity mismatch on the held word
//   frame_err   a stop-bit sample was low on the held word
//   overrun     sticky: a frame completed while the held word was unaccepted
//   busy        receiver is inside a frame
// master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 data_valid;
   logic                 data_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;
   logic                 busy;

   modport master (
      output data, data_valid, parity_err, frame_err, overrun, busy,
      input  data_ready
   );

   modport slave (
      input  data, data_valid, parity_err, frame_err, overrun, busy,
      output data_ready
   );
endinterface

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: 2-flop input synchroniser, false-start
// rejection, mid-bit sampling from the system clock, configurable data
// width / parity / stop bits, and a valid/ready output with parity, framing
// and overrun flags.
// Ports:
//   clk  system clock (posedge)
//   rst  asynchronous active-high reset
//   txd  serial line, idle high, asynchronous to clk
//   bus  output bundle (uart_rx_param_if.master)
// ---------------------------------------------------------------------------
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            txd,
   uart_rx_param_if.master bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
   localparam bit               ODD_PAR   = (PARITY == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               r_state, w_state_next;
   logic                 r_sync1, r_sync2, r_rx_prev;
   logic [CNT_W-1:0]     r_cnt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_acc, r_frm_acc;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid, r_perr, r_ferr, r_overrun;
   logic                 w_rx_s, w_sample, w_start, w_done, w_accept;

   assign w_rx_s   = r_sync2;
   assign w_sample = (r_cnt == '0);
   // A start needs a 1->0 transition, so a line stuck low (break) yields
   // one frame and then waits for the line to return high.
   assign w_start  = (r_state == S_IDLE) && !w_rx_s && r_rx_prev;
   assign w_accept = r_valid && bus.data_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= txd;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE:   if (w_start) w_state_next = S_START;
         S_START:  if (w_sample) w_state_next = w_rx_s ? S_IDLE : S_DATA;
         S_DATA:   if (w_sample && r_bit_cnt == LAST_DATA)
                      w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_sample) w_state_next = S_STOP;
         S_STOP:   if (w_sample && r_bit_cnt == LAST_STOP) begin
                      w_state_next = S_IDLE;
                      w_done       = 1'b1;
                   end
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Counter is loaded with half a bit on the start edge, then a full bit on
   // every sample, so each sample lands mid-bit without wrap-around logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par_acc <= 1'b0;
         r_frm_acc <= 1'b0;
      end else begin
         if (w_start)
            r_cnt <= CNT_HALF;
         else if (r_state != S_IDLE)
            r_cnt <= w_sample ? CNT_FULL : r_cnt - CNT_ONE;

         if (r_state != S_IDLE && w_sample) begin
            case (r_state)
               S_START: begin
                  r_bit_cnt <= '0;
                  r_par_acc <= 1'b0;
                  r_frm_acc <= 1'b0;
               end
               S_DATA: begin
                  r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? '0 : r_bit_cnt + BIT_ONE;
               end
               S_PARITY: r_par_acc <= w_rx_s ^ (^r_shift) ^ ODD_PAR;
               S_STOP: begin
                  r_frm_acc <= r_frm_acc | !w_rx_s;
                  r_bit_cnt <= r_bit_cnt + BIT_ONE;
               end
               default: ;
            endcase
         end
      end
   end

   // Delivery: a completing frame always loads; overrun only when the held
   // word is not being accepted in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_done) begin
         r_data  <= r_shift;
         r_perr  <= r_par_acc;
         r_ferr  <= r_frm_acc | !w_rx_s;
         r_valid <= 1'b1;
         if (r_valid && !bus.data_ready) r_overrun <= 1'b1;
         else if (w_accept)              r_overrun <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end
   end

   assign bus.data       = r_data;
   assign bus.data_valid = r_valid;
   assign bus.parity_err = (PARITY != 0) ? r_perr : 1'b0;
   assign bus.frame_err  = r_ferr;
   assign bus.overrun    = r_overrun;
   assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// dut0: C=4, 8N1.  dut1: C=4, 8 data bits, even parity, 2 stop bits.
// Expected values come from frame-level arithmetic: delivery cycle
// r + 2 + C/2 + (F-1)*C + 1 for a start edge driven in cycle r, data from
// the transmitted byte, parity/framing errors from the bits put on the line.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;
   localparam int C = 4;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic txd0 = 1'b1;
   logic txd1 = 1'b1;
   int   cyc  = 0;
   int   checks   = 0;
   int   failures = 0;

   uart_rx_param_if #(.DATA_BITS(8)) bus0 ();
   uart_rx_param_if #(.DATA_BITS(8)) bus1 ();

   uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .txd(txd0), .bus(bus0.master));
   uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .txd(txd1), .bus(bus1.master));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic dv(input int sel);
      return (sel != 0) ? bus1.data_valid : bus0.data_valid;
   endfunction
   function automatic logic [7:0] dat(input int sel);
      return (sel != 0) ? bus1.data : bus0.data;
   endfunction
   function automatic logic pe(input int sel);
      return (sel != 0) ? bus1.parity_err : bus0.parity_err;
   endfunction
   function automatic logic fe(input int sel);
      return (sel != 0) ? bus1.frame_err : bus0.frame_err;
   endfunction
   function automatic logic ov(input int sel);
      return (sel != 0) ? bus1.overrun : bus0.overrun;
   endfunction
   function automatic logic bsy(input int sel);
      return (sel != 0) ? bus1.busy : bus0.busy;
   endfunction

   function automatic int frame_len(input int sel);
      return (sel != 0) ? 12 : 10;
   endfunction
   function automatic int deliv_cycle(input int sel, input int r);
      return r + 2 + C / 2 + (frame_len(sel) - 1) * C + 1;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_neg(input int k);
      @(negedge clk);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic set_txd(input int sel, input logic v);
      if (sel != 0) txd1 = v;
      else          txd0 = v;
   endtask

   // Puts one frame on the line; the parity bit is even parity of d,
   // inverted when flip_par is set.  stop_v[0] is the first stop bit.
   task automatic send_frame(input int sel, input logic [7:0] d, input bit flip_par,
                             input bit [1:0] stop_v, output int r);
      bit bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (sel != 0) bits.push_back((^d) ^ flip_par);
      bits.push_back(stop_v[0]);
      if (sel != 0) bits.push_back(stop_v[1]);
      r = cyc;
      foreach (bits[i]) begin
         set_txd(sel, bits[i]);
         step(C);
      end
      set_txd(sel, 1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(3);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ({dat(s), dv(s), pe(s), fe(s), ov(s), bsy(s)} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs dut%0d: got %h expected 0", s,
                     {dat(s), dv(s), pe(s), fe(s), ov(s), bsy(s)});
         end
      end
      rst = 1'b0;
      step(4);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ({dv(s), bsy(s)} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset dut%0d: valid/busy=%b expected 00", s, {dv(s), bsy(s)});
         end
      end
   endtask

   task automatic test_basic;
      int r, k;
      bus0.data_ready = 1'b1;
      send_frame(0, 8'hA5, 1'b0, 2'b11, r);
      k = deliv_cycle(0, r);
      wait_neg(k - 1);
      checks++;
      if (dv(0) !== 1'b0) begin
         failures++; $display("FAIL basic_early: valid=%b expected 0 at cycle r+%0d", dv(0), k - 1 - r);
      end
      wait_neg(k);
      checks++;
      if ({dv(0), dat(0), pe(0), fe(0)} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL basic_deliver: valid=%b data=%h perr=%b ferr=%b expected 1 a5 0 0 at r+%0d",
                  dv(0), dat(0), pe(0), fe(0), k - r);
      end
      wait_neg(k + 1);
      checks++;
      if (dv(0) !== 1'b0) begin
         failures++; $display("FAIL basic_pulse: valid=%b expected 0 one cycle after delivery", dv(0));
      end
      step(1);
   endtask

   task automatic test_false_start;
      int r;
      bit seen;
      bit exp_busy [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      bus0.data_ready = 1'b1;
      step(2);
      r = cyc;
      set_txd(0, 1'b0);
      step(1);
      set_txd(0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         wait_neg(r + 2 + i);
         checks++;
         if (bsy(0) !== exp_busy[i]) begin
            failures++; $display("FAIL false_start_busy r+%0d: got %b expected %b", 2 + i, bsy(0), exp_busy[i]);
         end
      end
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (dv(0) !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++; $display("FAIL false_start_valid: got 1 expected 0 throughout");
      end
      step(1);
   endtask

   task automatic test_parity;
      int r;
      bit flips [2] = '{1'b1, 1'b0};
      bit exp_pe;
      bus1.data_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send_frame(1, 8'h03, flips[i], 2'b11, r);
         // line parity bit = even parity of data xor flip; receiver flags any mismatch
         exp_pe = (((^8'h03) ^ flips[i]) != (^8'h03));
         wait_neg(deliv_cycle(1, r));
         checks++;
         if ({dv(1), dat(1), pe(1), fe(1)} !== {1'b1, 8'h03, exp_pe, 1'b0}) begin
            failures++;
            $display("FAIL parity_%0d: valid=%b data=%h perr=%b ferr=%b expected 1 03 %b 0",
                     i, dv(1), dat(1), pe(1), fe(1), exp_pe);
         end
         step(3);
      end
   endtask

   task automatic test_framing_break;
      int r, n, at;
      logic [7:0] d, got_d;
      logic got_fe;
      bit seen;
      bus0.data_ready = 1'b1;
      send_frame(0, 8'h5A, 1'b0, 2'b10, r);
      wait_neg(deliv_cycle(0, r));
      checks++;
      if ({dv(0), dat(0), fe(0)} !== {1'b1, 8'h5A, 1'b1}) begin
         failures++;
         $display("FAIL frame_err: valid=%b data=%h ferr=%b expected 1 5a 1", dv(0), dat(0), fe(0));
      end
      step(4);
      r = cyc;
      set_txd(0, 1'b0);
      n = 0; at = -1; got_d = 8'hFF; got_fe = 1'b0;
      for (int i = 0; i < 120; i++) begin
         wait_neg(r + i);
         if (dv(0) === 1'b1) begin
            n++; at = cyc; got_d = dat(0); got_fe = fe(0);
         end
      end
      checks++;
      if (n != 1 || at != deliv_cycle(0, r) || got_d !== 8'h00 || got_fe !== 1'b1) begin
         failures++;
         $display("FAIL break_frame: frames=%0d at r+%0d data=%h ferr=%b expected 1 at r+%0d data=00 ferr=1",
                  n, at - r, got_d, got_fe, deliv_cycle(0, r) - r);
      end
      step(1);
      set_txd(0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dv(0) !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++; $display("FAIL break_release: got extra frame, expected none");
      end
      step(1);
      d = 8'($urandom);
      send_frame(0, d, 1'b0, 2'b11, r);
      wait_neg(deliv_cycle(0, r));
      checks++;
      if ({dv(0), dat(0), fe(0)} !== {1'b1, d, 1'b0}) begin
         failures++;
         $display("FAIL break_recover: valid=%b data=%h ferr=%b expected 1 %h 0", dv(0), dat(0), fe(0), d);
      end
      step(1);
   endtask

   task automatic test_overrun;
      int r;
      bus0.data_ready = 1'b0;
      send_frame(0, 8'h11, 1'b0, 2'b11, r);
      wait_neg(deliv_cycle(0, r));
      checks++;
      if ({dv(0), dat(0), ov(0)} !== {1'b1, 8'h11, 1'b0}) begin
         failures++; $display("FAIL overrun_first: valid=%b data=%h ovr=%b expected 1 11 0", dv(0), dat(0), ov(0));
      end
      step(1);
      send_frame(0, 8'h22, 1'b0, 2'b11, r);
      wait_neg(deliv_cycle(0, r));
      checks++;
      if ({dv(0), dat(0), ov(0)} !== {1'b1, 8'h22, 1'b1}) begin
         failures++; $display("FAIL overrun_set: valid=%b data=%h ovr=%b expected 1 22 1", dv(0), dat(0), ov(0));
      end
      step(1);
      bus0.data_ready = 1'b1;
      step(1);
      bus0.data_ready = 1'b0;
      wait_neg(cyc);
      checks++;
      if ({dv(0), ov(0)} !== 2'b00) begin
         failures++; $display("FAIL overrun_clear: valid/ovr=%b expected 00", {dv(0), ov(0)});
      end
      step(1);
      // accept in the very cycle a new frame completes
      send_frame(0, 8'h33, 1'b0, 2'b11, r);
      step(2);
      send_frame(0, 8'h44, 1'b0, 2'b11, r);
      bus0.data_ready = 1'b1;
      wait_neg(deliv_cycle(0, r));
      checks++;
      if ({dv(0), dat(0), ov(0)} !== {1'b1, 8'h44, 1'b0}) begin
         failures++; $display("FAIL accept_and_complete: valid=%b data=%h ovr=%b expected 1 44 0", dv(0), dat(0), ov(0));
      end
      wait_neg(deliv_cycle(0, r) + 1);
      checks++;
      if (dv(0) !== 1'b0) begin
         failures++; $display("FAIL accept_and_complete_drain: valid=%b expected 0", dv(0));
      end
      step(1);
   endtask

   task automatic test_reset_midframe;
      int r, r2;
      bit seen;
      bus0.data_ready = 1'b0;
      send_frame(0, 8'h77, 1'b0, 2'b11, r);
      wait_neg(deliv_cycle(0, r));
      checks++;
      if ({dv(0), dat(0)} !== {1'b1, 8'h77}) begin
         failures++; $display("FAIL hold_before_reset: valid=%b data=%h expected 1 77", dv(0), dat(0));
      end
      step(1);
      fork
         send_frame(0, 8'hC3, 1'b0, 2'b11, r);
         begin
            step(22);             // inside data bit 4 of the frame
            checks++;
            if (bsy(0) !== 1'b1) begin
               failures++; $display("FAIL midframe_busy: got %b expected 1", bsy(0));
            end
            #1 rst = 1'b1;
            #1;
            checks++;
            if ({dat(0), dv(0), pe(0), fe(0), ov(0), bsy(0)} !== 13'd0) begin
               failures++;
               $display("FAIL async_reset: outputs=%h expected 0", {dat(0), dv(0), pe(0), fe(0), ov(0), bsy(0)});
            end
         end
      join
      step(2);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (dv(0) !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++; $display("FAIL reset_discard: frame delivered after reset, expected none");
      end
      step(1);
      bus0.data_ready = 1'b1;
      send_frame(0, 8'h3C, 1'b0, 2'b11, r2);
      wait_neg(deliv_cycle(0, r2));
      checks++;
      if ({dv(0), dat(0), pe(0), fe(0), ov(0)} !== {1'b1, 8'h3C, 3'b000}) begin
         failures++;
         $display("FAIL after_reset_frame: valid=%b data=%h perr=%b ferr=%b ovr=%b expected 1 3c 0 0 0",
                  dv(0), dat(0), pe(0), fe(0), ov(0));
      end
      step(1);
   endtask

   // Random frames, back-to-back or with short gaps, occasional parity and
   // stop-bit corruption; a scoreboard checks every delivery and its cycle.
   task automatic test_random(input int sel, input int n);
      int         q_cyc[$];
      logic [7:0] q_dat[$];
      bit         q_pe[$];
      bit         q_fe[$];
      bit         sdone;
      int         g;
      if (sel != 0) bus1.data_ready = 1'b1;
      else          bus0.data_ready = 1'b1;
      sdone = 1'b0;
      fork
         begin
            bit last_low;
            last_low = 1'b0;
            for (int i = 0; i < n; i++) begin
               logic [7:0] d;
               bit         flip;
               bit [1:0]   stop_v;
               int         gap, r;
               d      = 8'($urandom);
               flip   = (sel != 0) && ($urandom_range(0, 3) == 0);
               stop_v = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
               gap    = $urandom_range(0, 3);
               // after a low final stop the line must go high before a new start counts
               if (last_low && gap == 0) gap = 1;
               if (gap > 0) step(gap);
               q_cyc.push_back(deliv_cycle(sel, cyc));
               q_dat.push_back(d);
               q_pe.push_back((sel != 0) && (((^d) ^ flip) != (^d)));
               q_fe.push_back(!stop_v[0] || ((sel != 0) && !stop_v[1]));
               last_low = (sel != 0) ? !stop_v[1] : !stop_v[0];
               send_frame(sel, d, flip, stop_v, r);
            end
            sdone = 1'b1;
         end
         begin
            g = 0;
            while (!(sdone && q_cyc.size() == 0) && g < 20000) begin
               @(negedge clk);
               g++;
               if (dv(sel) === 1'b1) begin
                  checks++;
                  if (q_cyc.size() == 0) begin
                     failures++; $display("FAIL rand%0d_unexpected: delivery at cycle %0d, none expected", sel, cyc);
                  end else begin
                     if (cyc != q_cyc[0] || {dat(sel), pe(sel), fe(sel), ov(sel)} !== {q_dat[0], q_pe[0], q_fe[0], 1'b0}) begin
                        failures++;
                        $display("FAIL rand%0d_frame: cycle=%0d data=%h perr=%b ferr=%b ovr=%b expected cycle=%0d data=%h perr=%b ferr=%b ovr=0",
                                 sel, cyc, dat(sel), pe(sel), fe(sel), ov(sel), q_cyc[0], q_dat[0], q_pe[0], q_fe[0]);
                     end
                     void'(q_cyc.pop_front()); void'(q_dat.pop_front());
                     void'(q_pe.pop_front());  void'(q_fe.pop_front());
                  end
               end else if (q_cyc.size() != 0 && cyc >= q_cyc[0]) begin
                  checks++; failures++;
                  $display("FAIL rand%0d_missing: no delivery at cycle %0d, expected data %h", sel, q_cyc[0], q_dat[0]);
                  void'(q_cyc.pop_front()); void'(q_dat.pop_front());
                  void'(q_pe.pop_front());  void'(q_fe.pop_front());
               end
            end
            if (g >= 20000) begin
               checks++; failures++;
               $display("FAIL rand%0d_timeout: %0d deliveries outstanding", sel, q_cyc.size());
            end
         end
      join
      step(1);
   endtask

   initial begin
      bus0.data_ready = 1'b1;
      bus1.data_ready = 1'b1;
      test_reset;
      test_basic;
      test_false_start;
      test_parity;
      test_framing_break;
      test_overrun;
      test_reset_midframe;
      test_random(0, 25);
      test_random(1, 15);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
